// File: rtl/edge_map_reader.sv
// rtl/edge_map_reader.sv - packs frame-RAM edge flags into 32-bit words and streams them out
module edge_map_reader #(
  parameter int START_ADDR = 2240,
  parameter int END_ADDR   = 74560,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk_div_by_two,
  input  logic        reset_n,
  input  logic        enable_edge_map_readout,
  input  logic [31:0] data_read,
  output logic [17:0] address,
  output logic [31:0] edge_word,
  output logic        edge_word_valid,
  input  logic        edge_word_ready,
  output logic        edge_word_last,
  output logic [17:0] edge_pixel_count,
  output logic        edge_map_readout_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_SAMPLE,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [17:0] LP_START    = 18'(START_ADDR);
  localparam logic [17:0] LP_END      = 18'(END_ADDR);
  localparam logic [1:0]  LP_LAT_LOAD = 2'(RD_LATENCY - 1);

  state_t      r_state;
  logic [4:0]  r_bit_idx;
  logic [1:0]  r_lat_cnt;
  logic        w_at_end;
  logic        w_pixel;
  logic        w_unused_data;

  assign w_at_end      = (address == LP_END);
  assign w_pixel       = data_read[0];
  // Only bit 0 of each RAM word carries the edge flag; the rest is don't-care.
  assign w_unused_data = ^data_read[31:1];

  // Readout FSM: address sequencing, read-latency wait, bit packing and word handshake.
  always_ff @(posedge clk_div_by_two or negedge reset_n) begin
    if (!reset_n) begin
      r_state               <= S_IDLE;
      r_bit_idx             <= 5'd0;
      r_lat_cnt             <= 2'd0;
      address               <= 18'd0;
      edge_word             <= 32'd0;
      edge_word_valid       <= 1'b0;
      edge_word_last        <= 1'b0;
      edge_pixel_count      <= 18'd0;
      edge_map_readout_done <= 1'b0;
    end else if (!enable_edge_map_readout) begin
      // Dropping enable aborts whatever is in flight; the pixel count is kept for inspection.
      r_state               <= S_IDLE;
      address               <= 18'd0;
      edge_word_valid       <= 1'b0;
      edge_word_last        <= 1'b0;
      edge_map_readout_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          address          <= LP_START;
          r_bit_idx        <= 5'd0;
          edge_word        <= 32'd0;
          edge_pixel_count <= 18'd0;
          r_state          <= S_ADDR;
        end
        S_ADDR: begin
          r_lat_cnt <= LP_LAT_LOAD;
          r_state   <= (RD_LATENCY == 1) ? S_SAMPLE : S_WAIT;
        end
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt - 2'd1;
          if (r_lat_cnt == 2'd1) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          edge_word[r_bit_idx] <= w_pixel;
          if (w_pixel) begin
            edge_pixel_count <= edge_pixel_count + 18'd1;
          end
          if ((r_bit_idx == 5'd31) || w_at_end) begin
            edge_word_valid <= 1'b1;
            edge_word_last  <= w_at_end;
            r_state         <= S_EMIT;
          end else begin
            r_bit_idx <= r_bit_idx + 5'd1;
            address   <= address + 18'd1;
            r_state   <= S_ADDR;
          end
        end
        S_EMIT: begin
          // Word, valid and last stay frozen until the consumer takes the word.
          if (edge_word_ready) begin
            edge_word_valid <= 1'b0;
            edge_word_last  <= 1'b0;
            if (edge_word_last) begin
              edge_map_readout_done <= 1'b1;
              r_state               <= S_DONE;
            end else begin
              edge_word <= 32'd0;
              r_bit_idx <= 5'd0;
              address   <= address + 18'd1;
              r_state   <= S_ADDR;
            end
          end
        end
        S_DONE: begin
          edge_map_readout_done <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_map_reader.sv
// tb/tb_edge_map_reader.sv - randomized self-checking bench for edge_map_reader at read latencies 1..3
module tb_edge_map_reader;

  localparam int START  = 2240;
  localparam int END_A  = 2368;
  localparam int NPIX   = END_A - START + 1;
  localparam int NWORDS = (NPIX + 31) / 32;
  localparam int CAP    = NWORDS + 4;
  localparam int LIMIT  = 8000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [2:0]  ready;
  logic [2:0]  valid;
  logic [2:0]  last;
  logic [2:0]  done;
  logic [31:0] word    [3];
  logic [31:0] data_rd [3];
  logic [17:0] addr    [3];
  logic [17:0] cnt     [3];

  logic [31:0] mem [NPIX];
  logic [31:0] exp_w [NWORDS];
  int          exp_cnt;

  logic        rnd_ready;
  logic        force0;
  logic        cap_clr;
  logic [31:0] cw [3][CAP];
  logic        cl [3][CAP];
  int          cn [3];
  logic        pv [3];
  logic        pr [3];
  logic        pl [3];
  logic [31:0] pw [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ram_rd(input logic [17:0] a);
    if (int'(a) >= START && int'(a) <= END_A) return mem[int'(a) - START];
    return 32'hFFFF_FFFE;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] pipe [3];
    always @(posedge clk) begin
      pipe[0] <= ram_rd(addr[g]);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign data_rd[g] = pipe[g];

    edge_map_reader #(
      .START_ADDR(START),
      .END_ADDR  (END_A),
      .RD_LATENCY(g + 1)
    ) u_dut (
      .clk_div_by_two         (clk),
      .reset_n                (reset_n),
      .enable_edge_map_readout(enable),
      .data_read              (data_rd[g]),
      .address                (addr[g]),
      .edge_word              (word[g]),
      .edge_word_valid        (valid[g]),
      .edge_word_ready        (ready[g]),
      .edge_word_last         (last[g]),
      .edge_pixel_count       (cnt[g]),
      .edge_map_readout_done  (done[g])
    );
  end

  // Capture accepted words and check that a stalled word stays frozen.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (cap_clr) begin
        cn[g] <= 0;
      end else if (valid[g] && ready[g]) begin
        if (cn[g] < CAP) begin
          cw[g][cn[g]] <= word[g];
          cl[g][cn[g]] <= last[g];
        end
        cn[g] <= cn[g] + 1;
      end
      if (pv[g] && !pr[g] && enable && reset_n) begin
        check($sformatf("hold_valid_L%0d", g + 1), {31'd0, valid[g]}, 32'd1);
        check($sformatf("hold_word_L%0d", g + 1), word[g], pw[g]);
        check($sformatf("hold_last_L%0d", g + 1), {31'd0, last[g]}, {31'd0, pl[g]});
      end
      pv[g] <= valid[g];
      pr[g] <= ready[g];
      pl[g] <= last[g];
      pw[g] <= word[g];
    end
  end

  // Ready driver: either tied high or random backpressure; instance 1 can be forced low.
  initial begin
    ready = 3'b111;
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        if (force0 && g == 1) ready[g] = 1'b0;
        else if (rnd_ready)   ready[g] = 1'($urandom_range(0, 1));
        else                  ready[g] = 1'b1;
      end
    end
  end

  task automatic fill(input int mode);
    for (int k = 0; k < NPIX; k++) begin
      case (mode)
        0:       mem[k] = 32'd0;
        1:       mem[k] = 32'(k % 2);
        2:       mem[k] = 32'hFFFF_FFFF;
        3:       mem[k] = 32'd0;
        default: mem[k] = $urandom;
      endcase
    end
    if (mode == 3) begin
      mem[0]        = 32'h0000_FFFE;
      mem[NPIX - 1] = 32'd1;
    end
  endtask

  // Reference: pixel k of the frame lands in word k/32 at bit k%32.
  task automatic build_exp();
    logic [31:0] m;
    exp_cnt = 0;
    for (int w = 0; w < NWORDS; w++) exp_w[w] = 32'd0;
    for (int k = 0; k < NPIX; k++) begin
      m = mem[k];
      if (m[0]) begin
        exp_w[k / 32] = exp_w[k / 32] | (32'd1 << (k % 32));
        exp_cnt++;
      end
    end
  endtask

  task automatic start_frame();
    enable  = 1'b0;
    cap_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cap_clr = 1'b0;
    enable  = 1'b1;
  endtask

  task automatic run_and_check(input string tag);
    int waited = 0;
    while (done != 3'b111 && waited < LIMIT) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check({tag, "_timeout"}, {31'd0, waited < LIMIT}, 32'd1);
    @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s_L%0d_count", tag, g + 1), 32'(cnt[g]), 32'(exp_cnt));
      check($sformatf("%s_L%0d_addr", tag, g + 1), 32'(addr[g]), 32'(END_A));
      check($sformatf("%s_L%0d_done", tag, g + 1), {31'd0, done[g]}, 32'd1);
      check($sformatf("%s_L%0d_valid", tag, g + 1), {31'd0, valid[g]}, 32'd0);
      check($sformatf("%s_L%0d_nwords", tag, g + 1), 32'(cn[g]), 32'(NWORDS));
      for (int w = 0; w < NWORDS && w < cn[g]; w++) begin
        check($sformatf("%s_L%0d_w%0d", tag, g + 1, w), cw[g][w], exp_w[w]);
        check($sformatf("%s_L%0d_last%0d", tag, g + 1, w), {31'd0, cl[g][w]},
              {31'd0, w == NWORDS - 1});
      end
    end
  endtask

  initial begin
    int          waited;
    logic [17:0] a0;
    logic [17:0] hold_cnt;

    reset_n   = 1'b0;
    enable    = 1'b0;
    rnd_ready = 1'b0;
    force0    = 1'b0;
    cap_clr   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 32'(addr[1]), 32'd0);
    check("rst_word", word[1], 32'd0);
    check("rst_valid", {31'd0, valid[1]}, 32'd0);
    check("rst_last", {31'd0, last[1]}, 32'd0);
    check("rst_count", 32'(cnt[1]), 32'd0);
    check("rst_done", {31'd0, done[1]}, 32'd0);
    reset_n = 1'b1;

    fill(0); build_exp(); start_frame(); run_and_check("zero");
    fill(1); build_exp(); start_frame(); run_and_check("alt");
    rnd_ready = 1'b1;
    fill(2); build_exp(); start_frame(); run_and_check("ones_bp");
    rnd_ready = 1'b0;
    fill(3); build_exp(); start_frame(); run_and_check("sparse");
    rnd_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      fill(4); build_exp(); start_frame(); run_and_check($sformatf("rand%0d", r));
    end
    rnd_ready = 1'b0;

    // Abort while the fifth word is stalled, then restart.
    fill(2); build_exp(); start_frame();
    waited = 0;
    while (cn[1] < 4 && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    force0 = 1'b1;
    while (!valid[1] && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    check("abort_reach_emit", {31'd0, waited < LIMIT}, 32'd1);
    @(posedge clk);
    #1;
    check("abort_stalled_valid", {31'd0, valid[1]}, 32'd1);
    hold_cnt = cnt[1];
    check("abort_count_before", 32'(hold_cnt), 32'(exp_cnt));
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("abort_valid", {31'd0, valid[1]}, 32'd0);
    check("abort_last", {31'd0, last[1]}, 32'd0);
    check("abort_done", {31'd0, done[1]}, 32'd0);
    check("abort_addr", 32'(addr[1]), 32'd0);
    check("abort_count_kept", 32'(cnt[1]), 32'(exp_cnt));
    force0  = 1'b0;
    cap_clr = 1'b1;
    @(posedge clk);
    #1;
    cap_clr = 1'b0;
    enable  = 1'b1;
    @(posedge clk);
    #1;
    check("restart_addr", 32'(addr[1]), 32'(START));
    check("restart_count", 32'(cnt[1]), 32'd0);
    run_and_check("abort_rerun");

    // Asynchronous reset pulse while the main instance waits on a read.
    fill(2); build_exp(); start_frame();
    repeat (40) @(posedge clk);
    #1;
    a0 = addr[1];
    waited = 0;
    while (addr[1] == a0 && waited < LIMIT) begin
      @(posedge clk);
      #1;
      waited++;
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    cap_clr = 1'b1;
    #1;
    check("arst_addr", 32'(addr[1]), 32'd0);
    check("arst_word", word[1], 32'd0);
    check("arst_valid", {31'd0, valid[1]}, 32'd0);
    check("arst_count", 32'(cnt[1]), 32'd0);
    check("arst_done", {31'd0, done[1]}, 32'd0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    cap_clr = 1'b0;
    @(posedge clk);
    #1;
    check("arst_restart_addr", 32'(addr[1]), 32'(START));
    run_and_check("reset_rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
